// File: rtl/global_int_pkg.sv
// Shared definitions for the global interrupt gateway.
//   ID_W       : width of a source ID (IDs 1..127, 0 reserved)
//   NO_ID      : the "no source" ID value
//   gw_state_t : per-source gateway state (IDLE / PENDING / INFLIGHT)
package global_int_pkg;

    localparam int ID_W = 7;
    localparam logic [ID_W-1:0] NO_ID = '0;

    typedef enum logic [1:0] {
        GW_IDLE     = 2'd0,
        GW_PENDING  = 2'd1,
        GW_INFLIGHT = 2'd2
    } gw_state_t;

endpackage

// File: rtl/global_int_gate.sv
// One interrupt source: input synchronizer plus the IDLE/PENDING/INFLIGHT
// gateway that latches a level request until it is claimed and completed.
// Ports:
//   clock    : rising-edge clock
//   reset    : asynchronous active-low reset
//   level    : raw level-sensitive interrupt line
//   claim    : this source is being claimed this cycle
//   complete : a completion for this source's ID is presented this cycle
//   pending  : gateway is in PENDING (registered)
module global_int_gate
    import global_int_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic level,
    input  logic claim,
    input  logic complete,
    output logic pending
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   synced;
    gw_state_t              state_reg;
    gw_state_t              state_next;

    if (SYNC_STAGES == 1) begin : g_sync_one
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                sync_reg <= '0;
            end else begin
                sync_reg <= level;
            end
        end
    end else begin : g_sync_multi
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                sync_reg <= '0;
            end else begin
                sync_reg <= {sync_reg[SYNC_STAGES-2:0], level};
            end
        end
    end

    assign synced = sync_reg[SYNC_STAGES-1];

    // The synchronized level is only looked at in IDLE, so assertions while
    // INFLIGHT are masked; a still-high level re-pends one cycle after IDLE.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            GW_IDLE:     if (synced)   state_next = GW_PENDING;
            GW_PENDING:  if (claim)    state_next = GW_INFLIGHT;
            GW_INFLIGHT: if (complete) state_next = GW_IDLE;
            default:                   state_next = GW_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= GW_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    assign pending = (state_reg == GW_PENDING);

endmodule

// File: rtl/global_int_gateway.sv
// Global interrupt gateway: N_SRC per-source gateways, a fixed-priority
// (lowest ID wins) claim encoder and claim/complete ID decode.
// Ports:
//   clock, reset        : clock and asynchronous active-low reset
//   interrupts[N_SRC]   : level interrupt lines, bit i = source ID i+1
//   enables[N_SRC]      : per-source claim enable mask
//   irq                 : any source pending and enabled
//   claim_valid/claim_id: lowest pending-and-enabled ID (0 when none)
//   claim_ready         : consumer takes claim_id this cycle
//   complete_valid/_id  : completion strobe and ID
module global_int_gateway
    import global_int_pkg::*;
#(
    parameter int N_SRC       = 127,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_SRC-1:0] interrupts,
    input  logic [N_SRC-1:0] enables,
    output logic             irq,
    output logic             claim_valid,
    output logic [ID_W-1:0]  claim_id,
    input  logic             claim_ready,
    input  logic             complete_valid,
    input  logic [ID_W-1:0]  complete_id
);

    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] claimable;
    logic             claim_fire;

    assign claimable  = pending & enables;
    assign claim_fire = claim_valid & claim_ready;

    // A completion only matches IDs 1..N_SRC, so ID 0 and out-of-range IDs
    // hit no gate; non-INFLIGHT gates ignore the strobe themselves.
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
        global_int_gate #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_gate (
            .clock   (clock),
            .reset   (reset),
            .level   (interrupts[gi]),
            .claim   (claim_fire && (claim_id == ID_W'(gi + 1))),
            .complete(complete_valid && (complete_id == ID_W'(gi + 1))),
            .pending (pending[gi])
        );
    end

    // Scan from the top down so the lowest set bit is the last assignment.
    always_comb begin
        claim_id = NO_ID;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (claimable[i]) begin
                claim_id = ID_W'(i + 1);
            end
        end
    end

    assign claim_valid = |claimable;
    assign irq         = claim_valid;

endmodule
